// File: rtl/ffs_pkg.sv
// Shared definitions for the find-first-set encoder/decoder pair:
// index depth rule and the decoder state type.
package ffs_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } ffs_dec_state_t;

    // Index width for a vector of w bits; a 1-bit vector still gets a 1-bit index.
    function automatic int ffs_depth(input int w);
        int d;
        d = 0;
        while ((1 << d) < w) d++;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/ffs_decoder_m_if.sv
// Index-stream input and frame-result output of ffs_decoder_m.
// in_*/out_* are strict valid/ready: a transfer occurs on a rising edge where valid && ready.
interface ffs_decoder_m_if
    import ffs_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 8
) ();
    localparam int INDEX_WIDTH = ffs_depth(OUTPUT_WIDTH);
    localparam int COUNT_WIDTH = $clog2(OUTPUT_WIDTH + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [INDEX_WIDTH-1:0]  in_index;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUTPUT_WIDTH-1:0] out_vec;
    logic [COUNT_WIDTH-1:0]  out_count;
    logic                    out_err;
    logic                    out_dup;
    ffs_dec_state_t          dbg_state;

    modport master (
        output in_valid, in_index, in_last, out_ready,
        input  in_ready, out_valid, out_vec, out_count, out_err, out_dup, dbg_state
    );

    modport slave (
        input  in_valid, in_index, in_last, out_ready,
        output in_ready, out_valid, out_vec, out_count, out_err, out_dup, dbg_state
    );
endinterface

// File: rtl/ffs_onehot_m.sv
// Combinational index-to-one-hot decoder; in_range_o is low when the index
// addresses no bit of the OUTPUT_WIDTH-bit vector.
module ffs_onehot_m
    import ffs_pkg::*;
#(
    parameter  int OUTPUT_WIDTH = 8,
    localparam int INDEX_WIDTH  = ffs_depth(OUTPUT_WIDTH)
) (
    input  logic [INDEX_WIDTH-1:0]  index_i,
    output logic [OUTPUT_WIDTH-1:0] onehot_o,
    output logic                    in_range_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < OUTPUT_WIDTH; i++) begin
            onehot_o[i] = (index_i == INDEX_WIDTH'(i));
        end
    end

    assign in_range_o = |onehot_o;

endmodule

// File: rtl/ffs_decoder_m.sv
// Streaming FFS decoder: rebuilds a bit vector from a frame of indices.
// Optional FFS_DECODER_DUP_CHECK_EN enables the duplicate-index flag (out_dup).
module ffs_decoder_m
    import ffs_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    ffs_decoder_m_if.slave bus
);
    localparam int COUNT_WIDTH = $clog2(OUTPUT_WIDTH + 1);
    localparam logic [0:0] S_ACCUM = ACCUM;
    localparam logic [0:0] S_HOLD  = HOLD;

    logic [0:0]              state_q, state_d;
    logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
    logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [OUTPUT_WIDTH-1:0] onehot;
    logic                    in_range;
    logic                    already;
    logic                    accept;
    logic                    consume;

    ffs_onehot_m #(.OUTPUT_WIDTH(OUTPUT_WIDTH)) u_onehot (
        .index_i    (bus.in_index),
        .onehot_o   (onehot),
        .in_range_o (in_range)
    );

    assign already = |(onehot & acc_q);
    assign accept  = bus.in_valid && (state_q == S_ACCUM);
    assign consume = bus.out_ready && (state_q == S_HOLD);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (accept) begin
            acc_d = acc_q | onehot;
            // Only a newly set bit counts, so the count never exceeds OUTPUT_WIDTH.
            if (in_range && !already) cnt_d = cnt_q + COUNT_WIDTH'(1);
            if (!in_range) err_d = 1'b1;
            if (bus.in_last) state_d = S_HOLD;
        end
        if (consume) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef FFS_DECODER_DUP_CHECK_EN
    logic dup_q, dup_d;

    always_comb begin
        dup_d = dup_q;
        if (accept && in_range && already) dup_d = 1'b1;
        if (consume) dup_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dup_q <= 1'b0;
        else        dup_q <= dup_d;
    end

    assign bus.out_dup = dup_q;
`else
    assign bus.out_dup = 1'b0;
`endif

    // Handshakes come from the state register only: no input-to-output paths.
    assign bus.in_ready  = (state_q == S_ACCUM);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_vec   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_err   = err_q;
    assign bus.dbg_state = ffs_dec_state_t'(state_q);

endmodule

// File: doc/ffs_decoder_m.md
# ffs_decoder_m

Streaming inverse of the find-first-set encoder. Accepts a stream of bit indices over a valid/ready handshake, sets the addressed bit of an internal accumulator, and on a `last`-flagged beat presents the rebuilt bit vector with a population count and error flags on an output valid/ready handshake. It sits on the consumer side of links that serialise a request mask as successive FFS indices, and rebuilds the mask at the far end.

## Interface
Parameters:
- `OUTPUT_WIDTH`, default 8: width of the rebuilt vector; legal range 1 and above.
- `INDEX_WIDTH` (localparam): `$clog2(max(OUTPUT_WIDTH,2))`, the same depth rule the encoder uses.
- `COUNT_WIDTH` (localparam): `$clog2(OUTPUT_WIDTH+1)`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  index beat valid.
- `in_ready`  out  1  decoder can accept a beat.
- `in_index`  in  INDEX_WIDTH  bit position to set.
- `in_last`  in  1  final beat of the frame.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_vec`  out  OUTPUT_WIDTH  rebuilt vector.
- `out_count`  out  COUNT_WIDTH  number of distinct bits set in `out_vec`.
- `out_err`  out  1  at least one beat in the frame had `in_index >= OUTPUT_WIDTH`.
- `out_dup`  out  1  at least one beat in the frame addressed a bit that was already set.

## Operation
- Two states: ACCUM and HOLD.
- Reset value: state is ACCUM, and the accumulator, count, err and dup are all 0. Output reset values are `out_valid=0`, `in_ready=1`, `out_vec=0`, `out_count=0`, `out_err=0`, `out_dup=0`.
- ACCUM: `in_ready=1`. A beat is accepted when `in_valid && in_ready`.
  - In-range index: set `acc[in_index]`. Increment count only if the bit was previously clear.
  - Index `>= OUTPUT_WIDTH`: the vector is unchanged and the sticky err flag is set.
  - Index of a bit that is already set: the vector is unchanged and the sticky dup flag is set.
- An accepted beat with `in_last=1` also moves the state to HOLD.
- HOLD: `in_ready=0` and `out_valid=1`. The `out_*` fields are driven from the registers and are stable until the result is accepted.
- On `out_valid && out_ready`: move to ACCUM, and clear the accumulator, count, err and dup on the same edge.
- A single-beat frame (`in_last` on the first beat) is legal. An empty frame is impossible, because every frame has at least one beat.
- Count saturation: count cannot exceed `OUTPUT_WIDTH`, because duplicates never increment it.

## Timing
- Latency: if the last beat is accepted at edge N, `out_valid` is high after edge N. That is one cycle from the last beat to the result.
- Throughput: one beat per cycle in ACCUM. Each frame also costs at least one HOLD cycle. There is no input acceptance in the cycle the result is consumed, because `in_ready` is registered off the state.
- `in_ready` and `out_valid` depend only on the state; there are no combinational paths from input to output handshake.
- When `out_ready` is held low, HOLD persists indefinitely and all `out_*` signals are frozen.
- Reset asserted mid-frame or in HOLD: on the next edge, all state returns to reset values and any partial frame is discarded.
- If `in_valid` is asserted while in HOLD, the beat is not accepted. The upstream must hold the beat.

## Configuration
- `FFS_DECODER_DUP_CHECK_EN` defined: dup detection is active as described above.
- Macro not defined:
  - The dup logic is removed and `out_dup` is tied to 0.
  - A repeated index still leaves the vector unchanged.
  - The count still counts distinct bits.

## Structure
- Shared package `ffs_pkg`:
  - The depth function `ffs_depth(w)` (returns `$clog2(max(w,2))`). The encoder and decoder both use it.
  - The state enum `ffs_dec_state_t {ACCUM, HOLD}`.
- One sub-module, `ffs_onehot_m`: a combinational index-to-one-hot decoder with `in_range` output, parameterised by `OUTPUT_WIDTH`. The top level ORs its result into the accumulator.

## Test plan
- Frame of indices 0, 3, 7 (last on 7), with `OUTPUT_WIDTH=8` and `out_ready=1`: `out_vec=8'h89`, `out_count=3`, `out_err=0`, `out_dup=0`, and `out_valid` is high for exactly one cycle, one cycle after the last beat.
- Frame 2, 2, 5 (last) with the macro defined: `out_vec=8'h24`, `out_count=2`, `out_dup=1`. With the macro undefined, the result is the same except `out_dup=0`.
- `OUTPUT_WIDTH=5`, frame 1, 6 (last): `out_vec=5'h02`, `out_count=1`, `out_err=1`.
- Hold `out_ready=0` for 4 cycles after a frame, with `in_valid` held high: `in_ready` stays 0, `out_*` stay stable, and no beat is accepted. After `out_ready=1`, the next frame starts from a cleared vector.
- Reset pulse after beats 4 and 6 without last: all outputs return to reset values. The next frame, 1 (last), yields `out_vec=8'h02` and `out_count=1`.
- Back-to-back single-beat frames 0, 7, 3 with `out_ready=1`: the results are `8'h01`, `8'h80` and `8'h08`, each with `out_count=1`, and frames complete every 2 cycles.
